// File: rtl/serial_adder.sv
// Bit-serial adder: one full-adder cell built from two half adders walks the
// operands LSB first and publishes {Cout,SUM} with a one-cycle DONE pulse.

module half_adder (
  input  logic a,
  input  logic b,
  output logic s,
  output logic c
);
  assign s = a ^ b;
  assign c = a & b;
endmodule

// state | meaning
// IDLE  | waiting for START; previous result held on SUM/Cout
// SHIFT | one operand bit added per clock, BUSY high
// FIN   | result valid, DONE high for this single cycle; START accepted here too
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             CIN,
  output logic             BUSY,
  output logic             DONE,
  output logic [WIDTH-1:0] SUM,
  output logic             Cout
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FIN   = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic [WIDTH-1:0] res_shift;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic ha0_s, ha0_c, bit_s, ha1_c, carry_nxt;
  logic last_bit, accept;

  half_adder u_ha0 (.a(a_q[0]), .b(b_q[0]),  .s(ha0_s), .c(ha0_c));
  half_adder u_ha1 (.a(ha0_s),  .b(carry_q), .s(bit_s), .c(ha1_c));

  assign carry_nxt = ha0_c | ha1_c;
  assign last_bit  = (cnt_q == CW'(WIDTH - 1));
  assign accept    = START && ((state_q == IDLE) || (state_q == FIN));

  // New sum bit enters at the MSB so the result is right-aligned after WIDTH shifts.
  always_comb begin
    res_shift            = res_q >> 1;
    res_shift[WIDTH-1]   = bit_s;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (START) state_d = SHIFT;
      SHIFT:   if (last_bit) state_d = FIN;
      FIN:     state_d = START ? SHIFT : IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
    if (accept) begin
      a_d     = A;
      b_d     = B;
      carry_d = CIN;
      res_d   = '0;
      cnt_d   = '0;
    end else if (state_q == SHIFT) begin
      a_d     = a_q >> 1;
      b_d     = b_q >> 1;
      res_d   = res_shift;
      carry_d = carry_nxt;
      cnt_d   = cnt_q + 1'b1;
      if (last_bit) begin
        sum_d  = res_shift;
        cout_d = carry_nxt;
      end
    end
  end

  always_comb begin
    BUSY = (state_q == SHIFT);
    DONE = (state_q == FIN);
  end

  assign SUM  = sum_q;
  assign Cout = cout_q;

endmodule

// File: tb/tb_serial_adder.sv
// Randomised scoreboard bench for serial_adder: stimulus pushes expected
// results with their acceptance cycle, a negedge monitor checks the handshake.

module tb_serial_adder;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst, start, cin;
  logic [W-1:0] a, b;
  logic         busy, done, cout;
  logic [W-1:0] sum;

  always #5 clk = ~clk;

  serial_adder #(.WIDTH(W)) dut (
    .CLK  (clk),
    .RST  (rst),
    .START(start),
    .A    (a),
    .B    (b),
    .CIN  (cin),
    .BUSY (busy),
    .DONE (done),
    .SUM  (sum),
    .Cout (cout)
  );

  typedef struct {
    int           acc;
    logic [W-1:0] s;
    logic         c;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           checks = 0;
  int           failures = 0;
  bit           chk_en = 1'b0;
  bit           rst_seen = 1'b0;
  logic [W-1:0] last_s = '0;
  logic         last_c = 1'b0;

  always @(posedge clk) begin
    cyc      <= cyc + 1;
    rst_seen <= rst;
  end

  function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h cyc=%0d", name, act, exp, cyc);
    end
  endfunction

  // Monitor: a result accepted at edge N keeps BUSY high for cycles N..N+W-1
  // and presents DONE in cycle N+W; SUM/Cout otherwise hold the last result.
  always @(negedge clk) begin
    bit be, de;
    if (rst_seen) begin
      sb.delete();
      last_s = '0;
      last_c = 1'b0;
    end
    if (chk_en) begin
      be = 1'b0;
      de = 1'b0;
      if (sb.size() > 0) begin
        be = (cyc >= sb[0].acc) && (cyc < sb[0].acc + W);
        de = (cyc == sb[0].acc + W);
      end
      check("busy", 32'(busy), 32'(be));
      check("done", 32'(done), 32'(de));
      if (de) begin
        last_s = sb[0].s;
        last_c = sb[0].c;
        sb.pop_front();
      end
      check("sum",  32'(sum),  32'(last_s));
      check("cout", 32'(cout), 32'(last_c));
    end
  end

  task automatic issue(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    logic [W:0] r;
    exp_t e;
    a     = x;
    b     = y;
    cin   = ci;
    start = 1'b1;
    r     = {1'b0, x} + {1'b0, y} + (W+1)'(ci);
    e.acc = cyc + 1;
    e.s   = r[W-1:0];
    e.c   = r[W];
    sb.push_back(e);
  endtask

  task automatic wait_done();
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      if (done) seen = 1'b1;
    end
    checks++;
    if (!seen) begin
      failures++;
      $display("FAIL done_timeout got=no_done exp=done cyc=%0d", cyc);
    end
  endtask

  task automatic run1(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci);
    issue(x, y, ci);
    @(negedge clk);
    start = 1'b0;
    a     = W'($urandom);
    b     = W'($urandom);
    cin   = 1'($urandom);
    wait_done();
    @(negedge clk);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog got=running exp=finished cyc=%0d", cyc);
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst   = 1'b1;
    start = 1'b0;
    a     = '0;
    b     = '0;
    cin   = 1'b0;
    repeat (2) @(negedge clk);
    rst    = 1'b0;
    chk_en = 1'b1;
    repeat (5) @(negedge clk);

    run1(8'h3C, 8'h42, 1'b0);
    repeat (20) @(negedge clk);
    run1(8'hFF, 8'h01, 1'b0);
    run1(8'hA5, 8'h5A, 1'b1);

    // Second START during SHIFT with different operands must be ignored.
    issue(8'h10, 8'h20, 1'b0);
    @(negedge clk);
    start = 1'b0;
    a     = 8'h77;
    b     = 8'h99;
    repeat (2) @(negedge clk);
    start = 1'b1;
    a     = 8'hFF;
    b     = 8'hFF;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    @(negedge clk);

    // START held high: second operation accepted in the FIN cycle.
    issue(8'h01, 8'h01, 1'b0);
    wait_done();
    issue(8'h80, 8'h80, 1'b0);
    @(negedge clk);
    start = 1'b0;
    wait_done();
    @(negedge clk);

    // Reset aborts an operation in flight.
    issue(8'hFF, 8'hFF, 1'b0);
    @(negedge clk);
    start = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    repeat (12) @(negedge clk);
    run1(8'h05, 8'h03, 1'b0);

    for (int n = 0; n < 40; n++) begin
      repeat ($urandom_range(0, 3)) @(negedge clk);
      run1(W'($urandom), W'($urandom), 1'($urandom));
    end

    repeat (3) @(negedge clk);
    check("sb_empty", 32'(sb.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
